lscnt_n: RTL and testbench

//  Parametrised loadable down counter; successor to the 1-bit LSCNTEL slice.

---
 rtl/lscnt_n.sv | 154 +++++++++++++++
 tb/tb_lscnt_n.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lscnt_n.sv
// ---------------------------------------------------------------------------
// lscnt_n -- parametrised loadable down counter with active-low borrow chain
//
// A WIDTH-bit counter with a captured reload register, optional auto-reload
// on underflow and a registered one-cycle terminal-count pulse. Stages
// cascade by wiring col_c_o of one instance into cil_i of the next; the
// borrow path has no register, so a chain resolves within one cycle.
//
// Optional feature (macro LSCNT_UPDN_EN): adds up_i to select counting
// up. With the macro undefined the counter is down-only and up_i is absent.
//
// Parameters
//   WIDTH        counter / reload word width (>= 2)
//   AUTO_RELOAD  1: on underflow/overflow load rv instead of wrapping
//
// Ports
//   clk_i    rising-edge clock
//   rstl_i   asynchronous active-low reset
//   ld_i     synchronous load strobe, highest priority
//   d_i      load data, copied to q and rv on ld_i
//   cil_i    active-low count enable / borrow in (0 = count this cycle)
//   up_i     count direction, 1 = up (LSCNT_UPDN_EN only)
//   q_o      counter value (registered)
//   ql_o     ~q_o (registered copy)
//   col_c_o  active-low borrow out (combinational)
//   tc_o     one-cycle terminal-count pulse (registered)
//   rv_o     reload register (registered)
// ---------------------------------------------------------------------------
module lscnt_n #(
    parameter int unsigned WIDTH       = 8,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk_i,
    input  logic             rstl_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             cil_i,
`ifdef LSCNT_UPDN_EN
    input  logic             up_i,
`endif
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] ql_o,
    output logic             col_c_o,
    output logic             tc_o,
    output logic [WIDTH-1:0] rv_o
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Per-edge operation, decoded in priority order.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_STEP = 2'd2,
        OP_WRAP = 2'd3
    } op_e;

    // State registers and their next-state values.
    logic [WIDTH-1:0] q_q,  q_d;
    logic [WIDTH-1:0] ql_q, ql_d;
    logic [WIDTH-1:0] rv_q, rv_d;
    logic             tc_q, tc_d;

    // Decode helpers.
    logic             up_c;
    logic             term_c;
    logic [WIDTH-1:0] step_val_c;
    logic [WIDTH-1:0] wrap_val_c;
    op_e              op_c;

    // Direction select; the default build counts down only.
`ifdef LSCNT_UPDN_EN
    assign up_c = up_i;
`else
    assign up_c = 1'b0;
`endif

    // Terminal value is the one whose next step borrows (down) or carries (up).
    always_comb begin
        term_c     = 1'b0;
        step_val_c = q_q;
        wrap_val_c = ALL_ONES;
        if (up_c) begin
            term_c     = (q_q == ALL_ONES);
            step_val_c = q_q + ONE;
            wrap_val_c = ALL_ZERO;
        end else begin
            term_c     = (q_q == ALL_ZERO);
            step_val_c = q_q - ONE;
            wrap_val_c = ALL_ONES;
        end
    end

    // Borrow out: low only when enabled and sitting on the terminal value.
    // Load does not gate it, so a chain stays combinational end to end.
    assign col_c_o = cil_i | ~term_c;

    // Operation decode: load beats count, count beats hold.
    always_comb begin
        op_c = OP_HOLD;
        if (ld_i) begin
            op_c = OP_LOAD;
        end else if (!cil_i) begin
            op_c = term_c ? OP_WRAP : OP_STEP;
        end
    end

    // Next-state logic; tc defaults low so it only ever lasts one cycle.
    always_comb begin
        q_d  = q_q;
        rv_d = rv_q;
        tc_d = 1'b0;
        unique case (op_c)
            OP_LOAD: begin
                q_d  = d_i;
                rv_d = d_i;
            end
            OP_STEP: begin
                q_d = step_val_c;
            end
            OP_WRAP: begin
                tc_d = 1'b1;
                q_d  = AUTO_RELOAD ? rv_q : wrap_val_c;
            end
            default: begin
                q_d = q_q;
            end
        endcase
        ql_d = ~q_d;
    end

    // State register; ql is kept as its own flop so the output is registered.
    always_ff @(posedge clk_i or negedge rstl_i) begin
        if (!rstl_i) begin
            q_q  <= ALL_ZERO;
            ql_q <= ALL_ONES;
            rv_q <= ALL_ZERO;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            ql_q <= ql_d;
            rv_q <= rv_d;
            tc_q <= tc_d;
        end
    end

    assign q_o  = q_q;
    assign ql_o = ql_q;
    assign rv_o = rv_q;
    assign tc_o = tc_q;

endmodule

// File: tb/tb_lscnt_n.sv
// Scoreboard bench for lscnt_n: stimulus pushes expected per-cycle state,
// a negedge monitor pops and compares.
module tb_lscnt_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstl;

    // dut0: WIDTH=8, wrap mode
    logic       ld0, cil0;
    logic [7:0] d0;
    logic [7:0] q0, ql0, rv0;
    logic       col0, tc0;
`ifdef LSCNT_UPDN_EN
    logic       up0;
`endif

    // dut1: WIDTH=8, auto-reload
    logic       ld1, cil1;
    logic [7:0] d1;
    logic [7:0] q1, ql1, rv1;
    logic       col1, tc1;

    // Cascade: two WIDTH=4 stages, lo borrow feeds hi enable
    logic       cld, ccil;
    logic [3:0] clo_d, chi_d;
    logic [3:0] lo_q, lo_ql, lo_rv, hi_q, hi_ql, hi_rv;
    logic       lo_col, lo_tc, hi_col, hi_tc;

    lscnt_n #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_dut0 (
        .clk_i(clk), .rstl_i(rstl), .ld_i(ld0), .d_i(d0), .cil_i(cil0),
`ifdef LSCNT_UPDN_EN
        .up_i(up0),
`endif
        .q_o(q0), .ql_o(ql0), .col_c_o(col0), .tc_o(tc0), .rv_o(rv0));

    lscnt_n #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_dut1 (
        .clk_i(clk), .rstl_i(rstl), .ld_i(ld1), .d_i(d1), .cil_i(cil1),
`ifdef LSCNT_UPDN_EN
        .up_i(1'b0),
`endif
        .q_o(q1), .ql_o(ql1), .col_c_o(col1), .tc_o(tc1), .rv_o(rv1));

    lscnt_n #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_lo (
        .clk_i(clk), .rstl_i(rstl), .ld_i(cld), .d_i(clo_d), .cil_i(ccil),
`ifdef LSCNT_UPDN_EN
        .up_i(1'b0),
`endif
        .q_o(lo_q), .ql_o(lo_ql), .col_c_o(lo_col), .tc_o(lo_tc), .rv_o(lo_rv));

    lscnt_n #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_hi (
        .clk_i(clk), .rstl_i(rstl), .ld_i(cld), .d_i(chi_d), .cil_i(lo_col),
`ifdef LSCNT_UPDN_EN
        .up_i(1'b0),
`endif
        .q_o(hi_q), .ql_o(hi_ql), .col_c_o(hi_col), .tc_o(hi_tc), .rv_o(hi_rv));

    typedef struct {
        int         cyc;
        int         id;
        string      tag;
        logic [7:0] q;
        logic [1:0] tc;
        logic       col;
        logic [7:0] rv;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected state for the current cycle (after the last edge, with current inputs).
    task automatic push(input int id, input string tag, input logic [7:0] q,
                        input logic [1:0] tc, input logic col, input logic [7:0] rv);
        exp_t e;
        e.cyc = cyc; e.id = id; e.tag = tag;
        e.q = q; e.tc = tc; e.col = col; e.rv = rv;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due by this cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] aq, aql, arv;
        logic [1:0] atc;
        logic       acol;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            case (e.id)
                0: begin aq = q0; aql = ql0; arv = rv0; atc = {1'b0, tc0}; acol = col0; end
                1: begin aq = q1; aql = ql1; arv = rv1; atc = {1'b0, tc1}; acol = col1; end
                default: begin
                    aq = {hi_q, lo_q}; aql = {hi_ql, lo_ql}; arv = {hi_rv, lo_rv};
                    atc = {hi_tc, lo_tc}; acol = hi_col;
                end
            endcase
            checks++;
            if (e.cyc != cyc || aq !== e.q || aql !== 8'(~e.q) || arv !== e.rv ||
                atc !== e.tc || acol !== e.col) begin
                fails++;
                $display("FAIL %s (cyc %0d/%0d): got q=%02h ql=%02h tc=%b col=%b rv=%02h, want q=%02h ql=%02h tc=%b col=%b rv=%02h",
                         e.tag, e.cyc, cyc, aq, aql, atc, acol, arv,
                         e.q, 8'(~e.q), e.tc, e.col, e.rv);
            end
        end
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    logic [7:0] t3_q   [7] = '{8'h02, 8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
    logic [1:0] t3_tc  [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    logic       t3_col [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rstl = 1'b0;
        ld0 = 1'b0; cil0 = 1'b1; d0 = 8'h00;
        ld1 = 1'b0; cil1 = 1'b1; d1 = 8'h00;
        cld = 1'b0; ccil = 1'b1; clo_d = 4'h0; chi_d = 4'h0;
`ifdef LSCNT_UPDN_EN
        up0 = 1'b0;
`endif
        tick(); tick();
        push(0, "rst_dut0", 8'h00, 2'b00, 1'b1, 8'h00);
        push(1, "rst_dut1", 8'h00, 2'b00, 1'b1, 8'h00);
        push(2, "rst_casc", 8'h00, 2'b00, 1'b1, 8'h00);
        tick(); rstl = 1'b1;

        // Async reset mid-count, then first count underflows from 0
        tick(); ld0 = 1'b1; d0 = 8'h37;
        tick(); ld0 = 1'b0; push(0, "t1_load", 8'h37, 2'b00, 1'b1, 8'h37);
        tick(); rstl = 1'b0; push(0, "t1_async_rst", 8'h00, 2'b00, 1'b1, 8'h00);
        tick(); rstl = 1'b1; cil0 = 1'b0; push(0, "t1_release", 8'h00, 2'b00, 1'b0, 8'h00);
        tick(); cil0 = 1'b1; push(0, "t1_underflow", 8'hFF, 2'b01, 1'b1, 8'h00);
        tick(); push(0, "t1_tc_end", 8'hFF, 2'b00, 1'b1, 8'h00);

        // Load 03 and count down through underflow
        tick(); ld0 = 1'b1; d0 = 8'h03;
        tick(); ld0 = 1'b0; cil0 = 1'b0; push(0, "t2_q03", 8'h03, 2'b00, 1'b1, 8'h03);
        tick(); push(0, "t2_q02", 8'h02, 2'b00, 1'b1, 8'h03);
        tick(); push(0, "t2_q01", 8'h01, 2'b00, 1'b1, 8'h03);
        tick(); push(0, "t2_q00_col", 8'h00, 2'b00, 1'b0, 8'h03);
        tick(); cil0 = 1'b1; push(0, "t2_qFF_tc", 8'hFF, 2'b01, 1'b1, 8'h03);
        tick(); push(0, "t2_tc_end", 8'hFF, 2'b00, 1'b1, 8'h03);

        // Load has priority over a concurrent underflow
        tick(); ld0 = 1'b1; d0 = 8'h00;
        tick(); d0 = 8'h10; cil0 = 1'b0; push(0, "t4_q00", 8'h00, 2'b00, 1'b0, 8'h00);
        tick(); ld0 = 1'b0; cil0 = 1'b1; push(0, "t4_ld_wins", 8'h10, 2'b00, 1'b1, 8'h10);

        // Auto-reload from 02
        tick(); ld1 = 1'b1; d1 = 8'h02;
        tick(); ld1 = 1'b0; cil1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            push(1, $sformatf("t3_ar_%0d", i), t3_q[i], t3_tc[i], t3_col[i], 8'h02);
        end
        tick(); cil1 = 1'b1; push(1, "t3_ar_hold", 8'h01, 2'b00, 1'b1, 8'h02);

        // Auto-reload with RV=0: stays 0, tc every enabled cycle
        tick(); ld1 = 1'b1; d1 = 8'h00;
        tick(); ld1 = 1'b0; cil1 = 1'b0; push(1, "t3_rv0_a", 8'h00, 2'b00, 1'b0, 8'h00);
        tick(); push(1, "t3_rv0_b", 8'h00, 2'b01, 1'b0, 8'h00);
        tick(); cil1 = 1'b1; push(1, "t3_rv0_c", 8'h00, 2'b01, 1'b1, 8'h00);
        tick(); push(1, "t3_rv0_d", 8'h00, 2'b00, 1'b1, 8'h00);

        // Cascade: 0x10 -> 0x0F -> 0x0E
        tick(); cld = 1'b1; clo_d = 4'h0; chi_d = 4'h1;
        tick(); cld = 1'b0; ccil = 1'b0; push(2, "t5_q10", 8'h10, 2'b00, 1'b1, 8'h10);
        tick(); push(2, "t5_q0F", 8'h0F, 2'b01, 1'b1, 8'h10);
        tick(); ccil = 1'b1; push(2, "t5_q0E", 8'h0E, 2'b00, 1'b1, 8'h10);
        tick(); push(2, "t5_hold", 8'h0E, 2'b00, 1'b1, 8'h10);

        // Cascade: full-chain underflow 0x00 -> 0xFF
        tick(); cld = 1'b1; clo_d = 4'h0; chi_d = 4'h0;
        tick(); cld = 1'b0; ccil = 1'b0; push(2, "t5_chain_col", 8'h00, 2'b00, 1'b0, 8'h00);
        tick(); ccil = 1'b1; push(2, "t5_chain_uf", 8'hFF, 2'b11, 1'b1, 8'h00);
        tick(); push(2, "t5_chain_end", 8'hFF, 2'b00, 1'b1, 8'h00);

`ifdef LSCNT_UPDN_EN
        // Up-count through overflow
        tick(); up0 = 1'b1; ld0 = 1'b1; d0 = 8'hFE; cil0 = 1'b1;
        tick(); ld0 = 1'b0; cil0 = 1'b0; push(0, "t6_qFE", 8'hFE, 2'b00, 1'b1, 8'hFE);
        tick(); push(0, "t6_qFF_col", 8'hFF, 2'b00, 1'b0, 8'hFE);
        tick(); push(0, "t6_q00_tc", 8'h00, 2'b01, 1'b1, 8'hFE);
        tick(); cil0 = 1'b1; push(0, "t6_q01", 8'h01, 2'b00, 1'b1, 8'hFE);
        tick(); up0 = 1'b0;
`endif

        tick(); tick(); tick();
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
